// File: rtl/register_pipe_pkg.sv
// ----------------------------------------------------------------------------
// register_pipe_pkg: shared types and sizing helper for the elastic pipe.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package register_pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } stage_state_e;

    // Floors at 1 bit so the DEPTH=0 build still has a legal o_count port.
    function automatic int count_width(input int depth);
        int w;
        w = $clog2(2 * depth + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/register_pipe_stage.sv
// ----------------------------------------------------------------------------
// register_pipe_stage: one two-entry skid stage (main M + skid S), registered
// handshake. Optional REGISTER_PIPE_FLUSH_EN adds flush_i. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module register_pipe_stage
    import register_pipe_pkg::*;
#(
    parameter int                    WORD_WIDTH  = 32,
    parameter logic [WORD_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clk_en,
`ifdef REGISTER_PIPE_FLUSH_EN
    input  logic                  flush_i,
`endif
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [WORD_WIDTH-1:0] in_data_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [WORD_WIDTH-1:0] out_data_o
);

    stage_state_e          state_q, state_d;
    logic [WORD_WIDTH-1:0] m_q, m_d;
    logic [WORD_WIDTH-1:0] s_q, s_d;
    logic                  live_q;
    logic                  w_flush;
    logic                  w_push;
    logic                  w_pop;

`ifdef REGISTER_PIPE_FLUSH_EN
    assign w_flush = flush_i;
`else
    assign w_flush = 1'b0;
`endif

    // Holds ready low while in reset and until the first edge after release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) live_q <= 1'b0;
        else          live_q <= 1'b1;
    end

    assign in_ready_o  = live_q && clk_en && (state_q != FULL) && !w_flush;
    assign out_valid_o = clk_en && (state_q != EMPTY);
    assign out_data_o  = m_q;

    assign w_push = in_valid_i && in_ready_o;
    assign w_pop  = out_valid_o && out_ready_i;

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        s_d     = s_q;
        if (w_flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (w_push) begin
                        m_d     = in_data_i;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (w_push && w_pop) begin
                        m_d = in_data_i;
                    end else if (w_push) begin
                        s_d     = in_data_i;
                        state_d = FULL;
                    end else if (w_pop) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (w_pop) begin
                        m_d     = s_q;
                        state_d = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= EMPTY;
            m_q     <= RESET_VALUE;
            s_q     <= RESET_VALUE;
        end else if (clk_en) begin
            state_q <= state_d;
            m_q     <= m_d;
            s_q     <= s_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/register_pipe.sv
// ----------------------------------------------------------------------------
// register_pipe: DEPTH cascaded skid stages with occupancy counter; DEPTH=0 is
// a passthrough. Optional REGISTER_PIPE_FLUSH_EN adds i_flush. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module register_pipe
    import register_pipe_pkg::*;
#(
    parameter int                    WORD_WIDTH  = 32,
    parameter int                    DEPTH       = 2,
    parameter logic [WORD_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          clk_en,
`ifdef REGISTER_PIPE_FLUSH_EN
    input  logic                          i_flush,
`endif
    input  logic                          i_valid,
    output logic                          o_ready,
    input  logic [WORD_WIDTH-1:0]         i_data,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic [WORD_WIDTH-1:0]         o_data,
    output logic [count_width(DEPTH)-1:0] o_count
);

    localparam int CW = count_width(DEPTH);

    generate
        if (DEPTH == 0) begin : g_bypass
`ifdef REGISTER_PIPE_FLUSH_EN
            assign o_ready = i_ready && clk_en && !i_flush;
`else
            assign o_ready = i_ready && clk_en;
`endif
            assign o_valid = i_valid && clk_en;
            assign o_data  = i_data;
            assign o_count = '0;
        end else begin : g_pipe
            logic                  w_valid [0:DEPTH];
            logic                  w_ready [0:DEPTH];
            logic [WORD_WIDTH-1:0] w_data  [0:DEPTH];
            logic [CW-1:0]         count_q, count_d;
            logic                  w_flush;

`ifdef REGISTER_PIPE_FLUSH_EN
            assign w_flush = i_flush;
`else
            assign w_flush = 1'b0;
`endif

            assign w_valid[0]     = i_valid;
            assign w_data[0]      = i_data;
            assign o_ready        = w_ready[0];
            assign o_valid        = w_valid[DEPTH];
            assign o_data         = w_data[DEPTH];
            assign w_ready[DEPTH] = i_ready;

            for (genvar k = 0; k < DEPTH; k++) begin : g_stage
                register_pipe_stage #(
                    .WORD_WIDTH  (WORD_WIDTH),
                    .RESET_VALUE (RESET_VALUE)
                ) u_stage (
                    .clk         (clk),
                    .reset_n     (reset_n),
                    .clk_en      (clk_en),
`ifdef REGISTER_PIPE_FLUSH_EN
                    .flush_i     (i_flush),
`endif
                    .in_valid_i  (w_valid[k]),
                    .in_ready_o  (w_ready[k]),
                    .in_data_i   (w_data[k]),
                    .out_valid_o (w_valid[k+1]),
                    .out_ready_i (w_ready[k+1]),
                    .out_data_o  (w_data[k+1])
                );
            end

            always_comb begin
                count_d = count_q;
                if (w_flush) begin
                    count_d = '0;
                end else begin
                    count_d = count_q + CW'(i_valid && o_ready) - CW'(o_valid && i_ready);
                end
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n)    count_q <= '0;
                else if (clk_en) count_q <= count_d;
            end

            assign o_count = count_q;
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_register_pipe.sv
// ----------------------------------------------------------------------------
// tb_register_pipe: randomized self-checking bench with a queue reference model.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_register_pipe;

    localparam int         WW  = 8;
    localparam int         DP  = 2;
    localparam logic [7:0] RV  = 8'hA5;
    localparam int         CW  = $clog2(2 * DP + 1);

    logic          clk = 1'b0;
    logic          reset_n;
    logic          clk_en;
    logic          i_valid;
    logic          o_ready;
    logic [WW-1:0] i_data;
    logic          o_valid;
    logic          i_ready;
    logic [WW-1:0] o_data;
    logic [CW-1:0] o_count;
`ifdef REGISTER_PIPE_FLUSH_EN
    logic          i_flush;
`endif

    int errors = 0;
    int checks = 0;
    logic [WW-1:0] model_q [$];

    register_pipe #(
        .WORD_WIDTH  (WW),
        .DEPTH       (DP),
        .RESET_VALUE (RV)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .clk_en  (clk_en),
`ifdef REGISTER_PIPE_FLUSH_EN
        .i_flush (i_flush),
`endif
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_data  (i_data),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_data  (o_data),
        .o_count (o_count)
    );

    always #5 clk = ~clk;

    // One clock cycle: drive, sample before the edge, update model, check count.
    task automatic do_cycle(input logic v, input logic [WW-1:0] d, input logic r,
                            output logic took_in, output logic ov, output logic ordy);
        logic [WW-1:0] exp_d;
        i_valid = v;
        i_data  = d;
        i_ready = r;
        #1;
        ov      = o_valid;
        ordy    = o_ready;
        took_in = v && o_ready;
        if (o_valid && r) begin
            checks++;
            exp_d = (model_q.size() > 0) ? model_q[0] : 'x;
            if (model_q.size() == 0 || o_data !== exp_d) begin
                errors++;
                $display("FAIL data_order: got %h expected %h (model size %0d)",
                         o_data, exp_d, model_q.size());
            end
            if (model_q.size() > 0) void'(model_q.pop_front());
        end
        if (took_in) model_q.push_back(d);
        @(posedge clk);
        #1;
        checks++;
        if (o_count !== CW'(model_q.size())) begin
            errors++;
            $display("FAIL count: got %0d expected %0d", o_count, model_q.size());
        end
    endtask

    task automatic drain(input string name);
        logic ti, ov, ordy;
        for (int i = 0; i < 20 && model_q.size() > 0; i++) do_cycle(1'b0, '0, 1'b1, ti, ov, ordy);
        checks++;
        if (model_q.size() != 0 || o_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_drain: left %0d words, o_valid=%b, expected 0 and 0",
                     name, model_q.size(), o_valid);
        end
    endtask

    task automatic test_reset();
        logic ti, ov, ordy;
        reset_n = 1'b0; clk_en = 1'b1; i_valid = 1'b0; i_ready = 1'b0; i_data = '0;
`ifdef REGISTER_PIPE_FLUSH_EN
        i_flush = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (o_valid !== 1'b0 || o_ready !== 1'b0 || o_data !== RV || o_count !== '0) begin
            errors++;
            $display("FAIL reset_state: v=%b r=%b d=%h c=%0d expected 0 0 a5 0",
                     o_valid, o_ready, o_data, o_count);
        end
        reset_n = 1'b1;
        #1;
        checks++;
        if (o_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_before_edge: got %b expected 0", o_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (o_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_release: got %b expected 1", o_ready);
        end
        do_cycle(1'b1, 8'h3C, 1'b0, ti, ov, ordy);
        do_cycle(1'b1, 8'h4D, 1'b0, ti, ov, ordy);
        #3;
        reset_n = 1'b0;
        #1;
        checks++;
        if (o_valid !== 1'b0 || o_data !== RV || o_count !== '0 || o_ready !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: v=%b d=%h c=%0d r=%b expected 0 a5 0 0",
                     o_valid, o_data, o_count, o_ready);
        end
        model_q.delete();
        i_valid = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_streaming();
        logic ti, ov, ordy;
        for (int cyc = 0; cyc < 20; cyc++) begin
            do_cycle(cyc < 16, WW'(cyc + 1), 1'b1, ti, ov, ordy);
            checks++;
            if (ov !== (cyc >= 2 && cyc <= 17)) begin
                errors++;
                $display("FAIL stream_valid: cycle %0d got %b expected %b",
                         cyc, ov, (cyc >= 2 && cyc <= 17));
            end
            if (cyc < 16) begin
                checks++;
                if (ordy !== 1'b1) begin
                    errors++;
                    $display("FAIL stream_ready: cycle %0d got %b expected 1", cyc, ordy);
                end
            end
        end
        drain("stream");
    endtask

    task automatic test_backpressure();
        logic ti, ov, ordy;
        logic [WW-1:0] nxt = 8'h01;
        int acc = 0;
        int first_rdy = -1;
        for (int i = 0; i < 8; i++) begin
            do_cycle(1'b1, nxt, 1'b0, ti, ov, ordy);
            if (ti) begin acc++; nxt++; end
        end
        checks++;
        if (acc != 2 * DP || o_ready !== 1'b0 || o_count !== CW'(2 * DP)) begin
            errors++;
            $display("FAIL backpressure_fill: accepted %0d r=%b c=%0d expected 4 0 4",
                     acc, o_ready, o_count);
        end
        for (int i = 0; i < 4; i++) begin
            do_cycle(1'b0, '0, 1'b1, ti, ov, ordy);
            if (ordy && first_rdy < 0) first_rdy = i;
        end
        checks++;
        if (first_rdy < 0 || first_rdy > 2) begin
            errors++;
            $display("FAIL backpressure_ready: reasserted at sample %0d expected 0..2", first_rdy);
        end
        drain("backpressure");
    endtask

    task automatic test_clk_en();
        logic ti, ov, ordy;
        logic [WW-1:0] nxt = 8'h61;
        logic [WW-1:0] held;
        for (int i = 0; i < 10 && model_q.size() < 3; i++) begin
            do_cycle(1'b1, nxt, 1'b0, ti, ov, ordy);
            if (ti) nxt++;
        end
        held = o_data;
        clk_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            do_cycle(1'b1, 8'h55, 1'b1, ti, ov, ordy);
            checks++;
            if (ov !== 1'b0 || ordy !== 1'b0 || o_data !== held || o_count !== CW'(3)) begin
                errors++;
                $display("FAIL clk_en_freeze: v=%b r=%b d=%h c=%0d expected 0 0 %h 3",
                         ov, ordy, o_data, o_count, held);
            end
        end
        clk_en = 1'b1;
        drain("clk_en");
    endtask

    task automatic test_random();
        logic ti, ov, ordy;
        for (int i = 0; i < 10000; i++)
            do_cycle(1'($urandom_range(0, 1)), WW'($urandom), 1'($urandom_range(0, 1)), ti, ov, ordy);
        drain("random");
    endtask

`ifdef REGISTER_PIPE_FLUSH_EN
    task automatic test_flush();
        logic ti, ov, ordy;
        logic [WW-1:0] nxt = 8'h21;
        for (int i = 0; i < 10 && model_q.size() < 3; i++) begin
            do_cycle(1'b1, nxt, 1'b0, ti, ov, ordy);
            if (ti) nxt++;
        end
        i_valid = 1'b1; i_data = 8'h77; i_ready = 1'b0; i_flush = 1'b1;
        #1;
        checks++;
        if (o_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_ready: got %b expected 0", o_ready);
        end
        @(posedge clk);
        #1;
        i_flush = 1'b0;
        model_q.delete();
        checks++;
        if (o_valid !== 1'b0 || o_count !== '0) begin
            errors++;
            $display("FAIL flush_clear: v=%b c=%0d expected 0 0", o_valid, o_count);
        end
        for (int i = 0; i < 6; i++) begin
            do_cycle(1'b0, '0, 1'b1, ti, ov, ordy);
            checks++;
            if (ov !== 1'b0) begin
                errors++;
                $display("FAIL flush_leak: o_valid=%b data=%h expected no word", ov, o_data);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_clk_en();
`ifdef REGISTER_PIPE_FLUSH_EN
        test_flush();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
